// File: rtl/oiia_tone_sequencer.sv
// Purpose : frame-locked "OI-I-A" chant generator; three square-wave notes, silent gaps, a rest, repeat.
// Latency : phase/busy update one clk after the deciding frame_tick; sound is registered (one clk).
// Backpr. : none; frame_tick is consumed unconditionally, enable only sampled in IDLE and at REST exit.
module oiia_tone_sequencer #(
  parameter int HP_W        = 16,
  parameter int HP_OI       = 14304,
  parameter int HP_I        = 11363,
  parameter int HP_A        = 19091,
  parameter int NOTE_FRAMES = 12,
  parameter int GAP_FRAMES  = 4,
  parameter int REST_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  output logic       sound,
  output logic [2:0] phase,
  output logic       busy
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int MAX_DUR = max3(NOTE_FRAMES, GAP_FRAMES, REST_FRAMES);
  localparam int FC_W    = $clog2(MAX_DUR) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OI   = 3'd1,
    ST_GAP1 = 3'd2,
    ST_I    = 3'd3,
    ST_GAP2 = 3'd4,
    ST_A    = 3'd5,
    ST_REST = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_succ;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [FC_W-1:0]   w_frame_cnt_nxt;
  logic [FC_W-1:0]   w_dur_m1;
  logic [HP_W-1:0]   r_tone_cnt;
  logic [HP_W-1:0]   w_hp_m1;
  logic              w_tone_state;
  logic              r_sound;
  logic              r_busy;

  // Per-state frame duration, tone half-period and the state that follows when the duration expires.
  always_comb begin
    w_dur_m1     = '0;
    w_hp_m1      = '0;
    w_tone_state = 1'b0;
    w_succ       = ST_IDLE;
    case (r_state)
      ST_OI: begin
        w_dur_m1     = FC_W'(NOTE_FRAMES - 1);
        w_hp_m1      = HP_W'(HP_OI - 1);
        w_tone_state = 1'b1;
        w_succ       = ST_GAP1;
      end
      ST_GAP1: begin
        w_dur_m1 = FC_W'(GAP_FRAMES - 1);
        w_succ   = ST_I;
      end
      ST_I: begin
        w_dur_m1     = FC_W'(NOTE_FRAMES - 1);
        w_hp_m1      = HP_W'(HP_I - 1);
        w_tone_state = 1'b1;
        w_succ       = ST_GAP2;
      end
      ST_GAP2: begin
        w_dur_m1 = FC_W'(GAP_FRAMES - 1);
        w_succ   = ST_A;
      end
      ST_A: begin
        w_dur_m1     = FC_W'(NOTE_FRAMES - 1);
        w_hp_m1      = HP_W'(HP_A - 1);
        w_tone_state = 1'b1;
        w_succ       = ST_REST;
      end
      ST_REST: begin
        w_dur_m1 = FC_W'(REST_FRAMES - 1);
        // enable is only honoured here, so a mid-sequence deassert lets the chant finish.
        w_succ   = enable ? ST_OI : ST_IDLE;
      end
      default: begin
        w_succ = ST_IDLE;
      end
    endcase
  end

  // Next-state and frame counter: advance only on frame_tick; unused code 7 falls back to IDLE.
  always_comb begin
    w_next_state    = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      ST_IDLE: begin
        w_frame_cnt_nxt = '0;
        if (frame_tick && enable) w_next_state = ST_OI;
      end
      ST_OI, ST_GAP1, ST_I, ST_GAP2, ST_A, ST_REST: begin
        if (frame_tick) begin
          if (r_frame_cnt == w_dur_m1) begin
            w_next_state    = w_succ;
            w_frame_cnt_nxt = '0;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + FC_W'(1);
          end
        end
      end
      default: begin
        w_next_state    = ST_IDLE;
        w_frame_cnt_nxt = '0;
      end
    endcase
  end

  // State, frame counter and busy registers; busy decodes the next state so it lines up with phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  // Tone generator: a state change beats a coincident wrap so each note starts from a clean low phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tone_cnt <= '0;
      r_sound    <= 1'b0;
    end else if (w_next_state != r_state) begin
      r_tone_cnt <= '0;
      r_sound    <= 1'b0;
    end else if (w_tone_state) begin
      if (r_tone_cnt == w_hp_m1) begin
        r_tone_cnt <= '0;
        r_sound    <= ~r_sound;
      end else begin
        r_tone_cnt <= r_tone_cnt + HP_W'(1);
      end
    end else begin
      r_tone_cnt <= '0;
      r_sound    <= 1'b0;
    end
  end

  assign sound = r_sound;
  assign phase = r_state;
  assign busy  = r_busy;

endmodule

// File: tb/tb_oiia_tone_sequencer.sv
// Purpose : directed bench for oiia_tone_sequencer with small half-periods and frame counts.
// Latency : outputs sampled 1 time unit after each rising clk edge.
// Backpr. : n/a; frame_tick is driven every 50 clks (one partial frame around the reset step).
module tb_oiia_tone_sequencer;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_OI   = 3'd1;
  localparam logic [2:0] P_GAP1 = 3'd2;
  localparam logic [2:0] P_I    = 3'd3;
  localparam logic [2:0] P_GAP2 = 3'd4;
  localparam logic [2:0] P_A    = 3'd5;
  localparam logic [2:0] P_REST = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       sound;
  logic [2:0] phase;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  int         tk    = 0;      // clks since entry into the current phase
  logic [2:0] prev_ph = 3'd0;

  oiia_tone_sequencer #(
    .HP_W        (16),
    .HP_OI       (4),
    .HP_I        (3),
    .HP_A        (5),
    .NOTE_FRAMES (2),
    .GAP_FRAMES  (1),
    .REST_FRAMES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .sound      (sound),
    .phase      (phase),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Square wave starts low at entry and toggles every hp clks.
  task automatic chk_all(input logic [2:0] ph, input int hp);
    logic exp_snd;
    exp_snd = (hp == 0) ? 1'b0 : (((tk / hp) % 2) == 1);
    chk("phase", 16'(phase), 16'(ph));
    chk("busy",  16'(busy),  16'(ph != P_IDLE));
    chk("sound", 16'(sound), 16'(exp_snd));
  endtask

  // One frame: a tick cycle followed by len-1 quiet cycles, every cycle checked.
  task automatic frame(input logic en, input logic [2:0] ph, input int hp, input int len);
    enable     = en;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (ph != prev_ph) tk = 0;
    else               tk++;
    prev_ph = ph;
    chk_all(ph, hp);
    for (int i = 1; i < len; i++) begin
      step();
      tk++;
      chk_all(ph, hp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    frame_tick = 1'b0;

    // Reset held for 3 clks.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all(P_IDLE, 0);
    end
    reset = 1'b0;

    // Idle with enable low: ticks are ignored for 200 clks.
    for (int i = 0; i < 4; i++) frame(1'b0, P_IDLE, 0, 50);

    // Full chant; OI exit tick lands exactly on a tone wrap (100 clks = 25 half-periods),
    // so GAP1 entry must show sound=0 with no glitch.
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_GAP1, 0, 50);
    frame(1'b1, P_I,    3, 50);
    frame(1'b1, P_I,    3, 50);
    frame(1'b1, P_GAP2, 0, 50);
    frame(1'b1, P_A,    5, 50);
    frame(1'b1, P_A,    5, 50);
    frame(1'b1, P_REST, 0, 50);
    frame(1'b1, P_REST, 0, 50);
    frame(1'b1, P_REST, 0, 50);
    // Seamless repeat.
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_GAP1, 0, 50);
    frame(1'b1, P_I,    3, 50);
    // enable dropped during I: sequence still completes.
    frame(1'b0, P_I,    3, 50);
    frame(1'b0, P_GAP2, 0, 50);
    frame(1'b0, P_A,    5, 50);
    frame(1'b0, P_A,    5, 50);
    frame(1'b0, P_REST, 0, 50);
    frame(1'b0, P_REST, 0, 50);
    frame(1'b0, P_REST, 0, 50);
    frame(1'b0, P_IDLE, 0, 50);
    frame(1'b0, P_IDLE, 0, 50);
    // Restart needs enable and a tick.
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_GAP1, 0, 50);
    frame(1'b1, P_I,    3, 50);
    frame(1'b1, P_I,    3, 50);
    frame(1'b1, P_GAP2, 0, 50);
    frame(1'b1, P_A,    5, 50);
    // Second A frame cut short at tk=56 where sound is high (56/5 = 11, odd).
    frame(1'b1, P_A,    5, 7);
    chk("sound_high_before_reset", 16'(sound), 16'd1);

    // Reset wins even with tick and enable asserted.
    reset      = 1'b1;
    frame_tick = 1'b1;
    enable     = 1'b1;
    step();
    chk("rst_sound", 16'(sound), 16'd0);
    chk("rst_phase", 16'(phase), 16'(P_IDLE));
    chk("rst_busy",  16'(busy),  16'd0);
    reset      = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b0;
    prev_ph    = P_IDLE;
    tk         = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all(P_IDLE, 0);
    end
    frame(1'b0, P_IDLE, 0, 50);
    // Frame count cleared by reset: OI dwells the full two frames.
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_OI,   4, 50);
    frame(1'b1, P_GAP1, 0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
